// File: rtl/adder_serial_ctrl.sv
// Parallel-to-serial operand driver and serial-to-parallel result collector for a bit-serial adder.
// Define SERIAL_CHECK_EN to add a reference adder and the sticky check_err output.
module adder_serial_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_CHECK_EN
    output logic             check_err,
`endif
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_c,
    output logic             ser_first,
    input  logic             ser_f,
    input  logic             ser_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]  cap_cnt_q, cap_cnt_d;
    logic             shift_act;
    logic             cap_en;
    logic             cap_last;

    assign shift_act = (state_q == StShift);
    assign cap_last  = cap_en && (cap_cnt_q == LastIdx);

    // cap_en marks the cycle in which the sum bit of a driven bit is present on ser_f.
    generate
        if (ADD_LAT == 0) begin : g_no_dly
            assign cap_en = shift_act;
        end else begin : g_dly
            logic [ADD_LAT-1:0] dly_q;

            always_ff @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    dly_q <= '0;
                end else begin
                    dly_q[0] <= shift_act;
                    for (int i = 1; i < ADD_LAT; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign cap_en = dly_q[ADD_LAT-1];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        c_d       = c_q;
        bit_cnt_d = bit_cnt_q;
        cap_cnt_d = cap_cnt_q;
        sum_sh_d  = sum_sh_q;
        sum_out_d = sum_out_q;
        carry_d   = carry_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d   = StShift;
                    a_sh_d    = a_in;
                    b_sh_d    = b_in;
                    c_d       = c_in;
                    bit_cnt_d = '0;
                    cap_cnt_d = '0;
                end
            end
            StShift: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == LastIdx) begin
                    state_d = (ADD_LAT == 0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (cap_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Bits arrive LSB-first, so capture index equals bit position.
        if (cap_en) begin
            sum_sh_d[cap_cnt_q] = ser_f;
            cap_cnt_d           = cap_cnt_q + CntW'(1);
            if (cap_last) begin
                sum_out_d = sum_sh_d;
                carry_d   = ser_co;
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= StIdle;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            c_q       <= 1'b0;
            bit_cnt_q <= '0;
            cap_cnt_q <= '0;
            sum_sh_q  <= '0;
            sum_out_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            c_q       <= c_d;
            bit_cnt_q <= bit_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            sum_sh_q  <= sum_sh_d;
            sum_out_q <= sum_out_d;
            carry_q   <= carry_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign ser_a     = shift_act & a_sh_q[0];
    assign ser_b     = shift_act & b_sh_q[0];
    assign ser_first = shift_act && (bit_cnt_q == '0);
    assign ser_c     = ser_first & c_q;
    assign sum_out   = sum_out_q;
    assign carry_out = carry_q;

`ifdef SERIAL_CHECK_EN
    logic [WIDTH:0] ref_q, ref_d;
    logic           err_q, err_d;

    always_comb begin
        ref_d = ref_q;
        err_d = err_q;
        if ((state_q == StIdle) && in_valid) begin
            ref_d = {1'b0, a_in} + {1'b0, b_in} + (WIDTH + 1)'(c_in);
        end
        // The final capture edge is the DONE entry edge.
        if (cap_last && ({ser_co, sum_sh_d} != ref_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ref_q <= '0;
            err_q <= 1'b0;
        end else begin
            ref_q <= ref_d;
            err_q <= err_d;
        end
    end

    assign check_err = err_q;
`endif

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Directed bench for adder_serial_ctrl with a one-cycle-latency loopback serial adder.
module tb_adder_serial_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned L = 1;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
    logic         ser_a;
    logic         ser_b;
    logic         ser_c;
    logic         ser_first;
    logic         ser_f;
    logic         ser_co;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         carry_out;
`ifdef SERIAL_CHECK_EN
    logic         check_err;
`endif

    int checks = 0;
    int errors = 0;

    adder_serial_ctrl #(
        .WIDTH  (W),
        .ADD_LAT(L)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_in     (c_in),
`ifdef SERIAL_CHECK_EN
        .check_err(check_err),
`endif
        .ser_a    (ser_a),
        .ser_b    (ser_b),
        .ser_c    (ser_c),
        .ser_first(ser_first),
        .ser_f    (ser_f),
        .ser_co   (ser_co),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    // Loopback serial full adder, registered once (ADD_LAT = 1), optional bit-3 sum fault.
    logic fault_en;
    logic m_carry, m_f, m_co, m_cin, m_sum, m_cout;
    int   m_bit, m_idx;

    assign m_cin  = ser_first ? ser_c : m_carry;
    assign m_sum  = ser_a ^ ser_b ^ m_cin;
    assign m_cout = (ser_a & ser_b) | (ser_a & m_cin) | (ser_b & m_cin);
    assign m_idx  = ser_first ? 0 : m_bit;
    assign ser_f  = m_f;
    assign ser_co = m_co;

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_carry <= 1'b0;
            m_f     <= 1'b0;
            m_co    <= 1'b0;
            m_bit   <= 0;
        end else begin
            m_f     <= m_sum ^ (fault_en && (m_idx == 3));
            m_co    <= m_cout;
            m_carry <= m_cout;
            m_bit   <= m_idx + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the out handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, output logic [W-1:0] s, output logic co,
                          output int lat);
        int first_cnt = 0;
        int first_at1 = 0;
        int c_cnt     = 0;
        int c_at1     = 0;
        int busy_rdy  = 0;
        logic [W-1:0] s0;
        logic         co0;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        a_in     = a;
        b_in     = b;
        c_in     = c;
        in_valid = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int cyc = 1; cyc <= 200 && lat < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
            if (ser_first) begin
                first_cnt++;
                if (cyc == 1) first_at1 = 1;
            end
            if (ser_c) begin
                c_cnt++;
                if (cyc == 1) c_at1 = 1;
            end
            if (in_ready) busy_rdy++;
            if (out_valid) lat = cyc;
        end
        chk("latency", 64'(lat), 64'(W + L + 1));
        chk("ser_first_count", 64'(first_cnt), 64'd1);
        chk("ser_first_cycle1", 64'(first_at1), 64'd1);
        chk("ser_c_count", 64'(c_cnt), 64'(c));
        chk("ser_c_cycle1", 64'(c_at1), 64'(c));
        chk("busy_in_ready", 64'(busy_rdy), 64'd0);
        s0  = sum_out;
        co0 = carry_out;
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 3 == 0);
            a_in     = $urandom;
            b_in     = $urandom;
            @(negedge clk);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_sum", 64'(sum_out), 64'(s0));
            chk("hold_carry", 64'(carry_out), 64'(co0));
        end
        in_valid  = 1'b0;
        s         = sum_out;
        co        = carry_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 64'(out_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_sum_held", 64'(sum_out), 64'(s));
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        int           hold;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t         vecs[7];
        logic [W-1:0] s;
        logic         co;
        int           lat;
        int           ov_seen;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0};
        vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 0};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 10};
        vecs[4] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 0};
        vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 0};

        n_reset   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        c_in      = 1'b0;
        fault_en  = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum_out), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);
        chk("rst_ser_first", 64'(ser_first), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].hold, s, co, lat);
            chk($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].s));
            chk($sformatf("vec%0d_carry", i), 64'(co), 64'(vecs[i].co));
        end

        // Abort mid-operation while bit 15 is on the serial lines.
        a_in     = 32'hFFFF_FFFF;
        b_in     = 32'hFFFF_FFFF;
        c_in     = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("abort_ser_a_before", 64'(ser_a), 64'd1);
        n_reset = 1'b0;
        #1;
        chk("abort_ser_a", 64'(ser_a), 64'd0);
        chk("abort_ser_b", 64'(ser_b), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_sum", 64'(sum_out), 64'd0);
        chk("abort_carry", 64'(carry_out), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("abort_no_result", 64'(ov_seen), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        run_op(32'd5, 32'd7, 1'b0, 0, s, co, lat);
        chk("after_abort_sum", 64'(s), 64'd12);
        chk("after_abort_carry", 64'(co), 64'd0);

`ifdef SERIAL_CHECK_EN
        chk("chk_err_clean", 64'(check_err), 64'd0);
        fault_en = 1'b1;
        run_op(32'd0, 32'd0, 1'b0, 0, s, co, lat);
        fault_en = 1'b0;
        chk("fault_sum", 64'(s), 64'h8);
        chk("chk_err_set", 64'(check_err), 64'd1);
        run_op(32'd3, 32'd4, 1'b0, 0, s, co, lat);
        chk("clean_sum", 64'(s), 64'd7);
        chk("chk_err_sticky", 64'(check_err), 64'd1);
        n_reset = 1'b0;
        #1;
        chk("chk_err_reset", 64'(check_err), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_serial_ctrl.md
Name: adder_serial_ctrl

Overview:
Parallel-to-serial operand driver and serial-to-parallel result collector for the bit-serial adder interface (per-bit Ai/Bi/Ci in, per-bit f/co out). It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and streams them LSB-first to the serial adder. It gathers the returned sum bits and final carry into a parallel result with its own valid/ready handshake. It sits between parallel datapath logic and the serial adder core.

Parameters:
WIDTH, 32, operand/sum width in bits (2..64)
ADD_LAT, 1, clk cycles from a bit driven on ser_a/ser_b to its sum bit on ser_f (0..4)

Ports:
clk  input  1  single clock; all state on rising edge
n_reset  input  1  reset; asynchronous, active-low
in_valid  input  1  operand request
in_ready  output  1  controller idle, can accept
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
c_in  input  1  carry-in
ser_a  output  1  serial A bit to adder (Ai)
ser_b  output  1  serial B bit to adder (Bi)
ser_c  output  1  carry-in to adder (Ci); valid on first bit only
ser_first  output  1  high on bit 0 of each operation
ser_f  input  1  serial sum bit from adder
ser_co  input  1  carry-out from adder, sampled with last sum bit
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum_out  output  WIDTH  collected sum
carry_out  output  1  collected carry-out

Behaviour:
- Reset (n_reset low, async): state IDLE; bit/capture counters, shift regs, sum_out, carry_out, out_valid, ser_* all 0. in_ready is decoded from state, so it is 1 once in IDLE.
- States: IDLE, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. When in_valid=1, latch a_in/b_in/c_in, clear counters and go to SHIFT. in_valid=0 keeps IDLE.
- SHIFT (exactly WIDTH cycles):
  - ser_a/ser_b = LSB of A/B shift regs; regs shift right each cycle.
  - ser_first=1 and ser_c=latched c_in on bit 0 only; otherwise both 0.
  - After bit WIDTH-1 go to DRAIN, or directly to DONE if ADD_LAT=0.
- Outside SHIFT, ser_a/ser_b/ser_c/ser_first are 0.
- Capture:
  - A delay line of ADD_LAT stages tracks which cycles carry a valid bit; with ADD_LAT=0, capture is in the same cycle the bit is driven.
  - On each valid capture cycle: sum_sh <= {ser_f, sum_sh[WIDTH-1:1]}.
  - On the WIDTH-th capture, also register ser_co into carry_out.
- DRAIN: wait until the WIDTH-th capture completes, then go to DONE.
- DONE: out_valid=1; sum_out/carry_out held stable. On out_ready=1, go to IDLE; out_valid falls the next cycle. out_ready=0 holds DONE indefinitely.
- Timing: acceptance at edge 0, bit k driven in cycle k+1, out_valid high from cycle WIDTH+ADD_LAT+1. For WIDTH=32, ADD_LAT=1: cycle 34.
- Throughput: one operation at a time; in_ready=0 in SHIFT, DRAIN and DONE; in_valid is ignored there. A new acceptance is possible the cycle after the out handshake.
- sum_out/carry_out keep the last result until the next operation completes; they are not cleared on IDLE.
- n_reset low mid-operation aborts immediately; no partial result is emitted.

Optional Feature:
SERIAL_CHECK_EN: when defined, the block latches the full-width reference {carry,sum} = a_in+b_in+c_in at acceptance and compares it to the collected result on entry to DONE. It adds output check_err (1 bit), sticky-set on mismatch and cleared only by reset. When undefined, no check_err port and no adder logic are present.

Test Plan:
- a=0, b=0, c=0 (WIDTH=32, ADD_LAT=1) with loopback serial adder -> sum_out=0x00000000, carry_out=0, out_valid rises cycle 34.
- a=0xFFFFFFFF, b=0x00000001, c=0 -> sum_out=0x00000000, carry_out=1; ser_first high only in cycle 1.
- a=0x12345678, b=0x9ABCDEF0, c=1 -> sum_out=0xACF13569, carry_out=0; ser_c=1 only on bit 0.
- a=0x80000000, b=0x80000000, c=1; hold out_ready=0 for 10 cycles -> out_valid stays 1, sum_out=0x00000001, carry_out=1 stable; in_valid pulses during that time ignored (in_ready=0).
- Assert n_reset low at bit 15 of an operation -> all outputs 0 asynchronously; after release in_ready=1; next op a=5, b=7, c=0 -> sum_out=12, carry_out=0.
- With SERIAL_CHECK_EN and a fault-injecting adder model flipping bit 3 of f -> check_err=1 at DONE, remains 1 through subsequent correct operations until reset.
